// File: rtl/micro_run_ctrl.sv
// micro_run_ctrl: run-control and debug front end for a small microcontroller.
// Gates the core's clock enable (run / halt / single-step / breakpoint), owns
// the 4x8 data memory shared by the CPU and a host debug port, and counts
// executed instructions.
module micro_run_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       bp_en,
  input  logic [7:0] bp_addr,
  input  logic [7:0] pc,
  input  logic       cpu_mem_wr,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [1:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic       halted,
  output logic       bp_hit,
  output logic [15:0] icount
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HOST = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  // Set only during the first RUN cycle after leaving HALT, so a resume at a
  // breakpoint address executes that instruction once before re-arming.
  logic first_run_q;
  logic bp_fire;
  logic bp_clr;
  logic cpu_en_d;

  // Data memory is not reset: contents survive a debug reset.
  logic [DATA_W-1:0] mem [4] = '{8'd10, 8'd9, 8'd0, 8'd0};

  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign cpu_rdata = mem[cpu_addr];
  // Reset kills the enable immediately, independent of the state register.
  assign cpu_en    = cpu_en_d & ~reset;

  // Next-state, clock-enable and grant decode.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    bp_fire  = 1'b0;
    bp_clr   = 1'b0;
    host_gnt = 1'b0;
    case (state_q)
      S_HALT: begin
        if (run_req) begin
          state_d = S_RUN;
          bp_clr  = 1'b1;
        end else if (step_req) begin
          state_d = S_STEP;
          bp_clr  = 1'b1;
        end else if (host_req && !host_ack) begin
          state_d = S_HOST;
        end
      end
      S_RUN: begin
        if (bp_en && (pc == bp_addr) && !first_run_q) begin
          // Breakpoint wins over halt_req: the instruction is not executed.
          bp_fire = 1'b1;
          state_d = S_HALT;
        end else begin
          cpu_en_d = 1'b1;
          if (halt_req) state_d = S_HALT;
        end
      end
      S_STEP: begin
        cpu_en_d = 1'b1;
        state_d  = S_HALT;
      end
      S_HOST: begin
        host_gnt = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Control state: FSM, breakpoint flag, instruction counter, host handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HALT;
      first_run_q <= 1'b0;
      bp_hit      <= 1'b0;
      icount      <= 16'd0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state_q     <= state_d;
      first_run_q <= (state_q == S_HALT) && (state_d == S_RUN);
      if (bp_fire)     bp_hit <= 1'b1;
      else if (bp_clr) bp_hit <= 1'b0;
      if (cpu_en)      icount <= icount + 16'd1;
      host_ack <= (state_q == S_HOST);
      // Read-before-write: the host sees the value held before its own write.
      if (state_q == S_HOST) host_rdata <= mem[host_addr];
    end
  end

  // Memory write port; CPU and host can never be enabled in the same cycle.
  always_ff @(posedge clk) begin
    if (cpu_en && cpu_mem_wr)        mem[cpu_addr]  <= cpu_wdata;
    else if (host_gnt && host_we)    mem[host_addr] <= host_wdata;
  end

endmodule
